// File: rtl/ahbs_mem.sv
// ahbs_mem: AHB-Lite slave backed by a P_DEPTH x 32-bit memory (1 KB window).
// Configurable OKAY wait states (P_WAIT, 0-3), two-cycle ERROR response for
// illegal sizes, misaligned or out-of-window accesses, byte-lane writes, and
// read-after-write forwarding for a read accepted on a write's completing edge.
//
// Ports:
//   I_AHBS_HCLK       clock, all state on rising edge
//   I_AHBS_HRESET     synchronous active-high reset
//   I_AHBS_HSEL       slave select
//   I_AHBS_HADDR      transfer address
//   I_AHBS_HWDATA     write data (data phase)
//   I_AHBS_HSIZE      000 byte, 001 halfword, 010 word
//   I_AHBS_HBURST     burst type (ignored)
//   I_AHBS_HTRANS     IDLE/BUSY/NSEQ/SEQ
//   I_AHBS_HWRITE     1 write, 0 read
//   I_AHBS_HREADY     bus-level ready
//   O_AHBS_HRDATA     registered read data
//   O_AHBS_HREADYOUT  slave ready
//   O_AHBS_HRESP      00 OKAY, 01 ERROR
module ahbs_mem #(
    parameter int P_WAIT  = 0,
    parameter int P_DEPTH = 256
) (
    input  logic        I_AHBS_HCLK,
    input  logic        I_AHBS_HRESET,
    input  logic        I_AHBS_HSEL,
    input  logic [31:0] I_AHBS_HADDR,
    input  logic [31:0] I_AHBS_HWDATA,
    input  logic [2:0]  I_AHBS_HSIZE,
    input  logic [2:0]  I_AHBS_HBURST,
    input  logic [1:0]  I_AHBS_HTRANS,
    input  logic        I_AHBS_HWRITE,
    input  logic        I_AHBS_HREADY,
    output logic [31:0] O_AHBS_HRDATA,
    output logic        O_AHBS_HREADYOUT,
    output logic [1:0]  O_AHBS_HRESP
);

    localparam int AW = $clog2(P_DEPTH);
    localparam logic [1:0] WAIT_LOAD = (P_WAIT > 0) ? 2'(P_WAIT - 1) : 2'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t         state, state_nxt;
    logic [1:0]     wait_cnt, wait_cnt_nxt;

    // Latched address phase of the transfer currently in its data phase.
    logic           ph_valid;
    logic           ph_write;
    logic [AW-1:0]  ph_idx;
    logic [1:0]     ph_lane;
    logic [2:0]     ph_size;

    logic [31:0]    mem [P_DEPTH];

    logic           ready;
    logic           accept;
    logic           acc_err;
    logic [AW-1:0]  acc_idx;
    logic           commit;
    logic [31:0]    wr_word;

    logic           unused_bits;
    assign unused_bits = ^{I_AHBS_HBURST, I_AHBS_HTRANS[0], I_AHBS_HADDR[31:12]};

    assign ready            = (state != S_WAIT) && (state != S_ERR1);
    assign O_AHBS_HREADYOUT = ready;
    assign O_AHBS_HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;

    // Own ready is folded in so a misbehaving HREADY during our own wait or
    // first error cycle cannot overwrite the latched phase.
    assign accept  = I_AHBS_HSEL && I_AHBS_HREADY && I_AHBS_HTRANS[1] && ready;
    assign acc_idx = I_AHBS_HADDR[AW+1:2];
    assign acc_err = (I_AHBS_HSIZE > 3'b010)
                  || (I_AHBS_HSIZE == 3'b001 && I_AHBS_HADDR[0])
                  || (I_AHBS_HSIZE == 3'b010 && I_AHBS_HADDR[1:0] != 2'b00)
                  || (I_AHBS_HADDR[11:10] != 2'b00);

    // A write lands on the edge where its data phase completes.
    assign commit = ph_valid && ph_write && ready;

    // Post-write word: also the forwarding source for a same-edge read.
    always_comb begin
        wr_word = mem[ph_idx];
        case (ph_size)
            3'b000: wr_word[{ph_lane, 3'b000} +: 8] = I_AHBS_HWDATA[{ph_lane, 3'b000} +: 8];
            3'b001: begin
                if (ph_lane[1]) wr_word[31:16] = I_AHBS_HWDATA[31:16];
                else            wr_word[15:0]  = I_AHBS_HWDATA[15:0];
            end
            default: wr_word = I_AHBS_HWDATA;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (acc_err) begin
                        state_nxt = S_ERR1;
                    end else if (P_WAIT > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 2'd0) state_nxt = S_IDLE;
                else                  wait_cnt_nxt = wait_cnt - 2'd1;
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_AHBS_HCLK) begin
        if (I_AHBS_HRESET) begin
            state         <= S_IDLE;
            wait_cnt      <= 2'd0;
            ph_valid      <= 1'b0;
            ph_write      <= 1'b0;
            ph_idx        <= '0;
            ph_lane       <= 2'd0;
            ph_size       <= 3'd0;
            O_AHBS_HRDATA <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (ready) begin
                // Erroring transfers never get a valid phase: no array access.
                ph_valid <= accept && !acc_err;
                if (accept) begin
                    ph_write <= I_AHBS_HWRITE;
                    ph_idx   <= acc_idx;
                    ph_lane  <= I_AHBS_HADDR[1:0];
                    ph_size  <= I_AHBS_HSIZE;
                    if (!I_AHBS_HWRITE) begin
                        if (acc_err)                           O_AHBS_HRDATA <= 32'd0;
                        else if (commit && ph_idx == acc_idx)  O_AHBS_HRDATA <= wr_word;
                        else                                   O_AHBS_HRDATA <= mem[acc_idx];
                    end
                end
            end
        end
    end

    // Array has no reset; a reset edge also cancels any pending write.
    always_ff @(posedge I_AHBS_HCLK) begin
        if (!I_AHBS_HRESET && commit) mem[ph_idx] <= wr_word;
    end

endmodule

// File: tb/tb_ahbs_mem.sv
// Bench for ahbs_mem: three instances (P_WAIT 0, 2, 1), one selected at a
// time, each with HREADY looped back from its own HREADYOUT. The driver
// pushes the expected response of every accepted transfer into a queue; a
// negedge monitor tracks data phases, counts wait cycles and compares.
module tb_ahbs_mem;

    typedef struct {
        bit          is_rd;
        bit          abandon;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          act = 0;
    logic [31:0] haddr = 32'd0;
    logic [31:0] hwdata = 32'd0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;

    logic [31:0] rdata_a [3];
    logic        ro_a    [3];
    logic [1:0]  resp_a  [3];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        ahbs_mem #(.P_WAIT(k == 0 ? 0 : (k == 1 ? 2 : 1)), .P_DEPTH(256)) u_dut (
            .I_AHBS_HCLK     (clk),
            .I_AHBS_HRESET   (rst),
            .I_AHBS_HSEL     (act == k),
            .I_AHBS_HADDR    (haddr),
            .I_AHBS_HWDATA   (hwdata),
            .I_AHBS_HSIZE    (hsize),
            .I_AHBS_HBURST   (hburst),
            .I_AHBS_HTRANS   (htrans),
            .I_AHBS_HWRITE   (hwrite),
            .I_AHBS_HREADY   (ro_a[k]),
            .O_AHBS_HRDATA   (rdata_a[k]),
            .O_AHBS_HREADYOUT(ro_a[k]),
            .O_AHBS_HRESP    (resp_a[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one address phase and return #1 after the edge that takes it,
    // leaving wd on HWDATA for the data phase that follows.
    task automatic xfer(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                        input logic wr, input logic [31:0] wd, input logic [31:0] rexp,
                        input logic [1:0] rsp, input int w, input bit ab);
        exp_t e;
        int   n;
        htrans = tr; haddr = a; hsize = sz; hwrite = wr;
        if (tr[1]) begin
            e.is_rd = !wr; e.abandon = ab; e.rdata = rexp; e.resp = rsp; e.waits = w;
            q.push_back(e);
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (ro_a[act]) break;
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL addr_phase_timeout actual=stalled required=ready addr=%h", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        hwdata = wd;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                      input logic [1:0] rsp, input int w);
        xfer(2'b10, a, sz, 1'b1, d, 32'd0, rsp, w, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] x,
                      input logic [1:0] rsp, input int w);
        xfer(2'b10, a, sz, 1'b0, 32'd0, x, rsp, w, 1'b0);
    endtask

    task automatic idle();
        xfer(2'b00, 32'd0, 3'd2, 1'b0, 32'd0, 32'd0, 2'b00, 0, 1'b0);
    endtask

    // Monitor: one data phase at a time; non-transfer cycles must be
    // zero-wait OKAY.
    initial begin
        bit   pending = 0;
        int   wcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pending && q.size() > 0) begin
                    e = q.pop_front();
                    if (!e.abandon) begin
                        checks++; errors++;
                        $display("FAIL reset_drop actual=dropped required=completed");
                    end
                end
                pending = 0;
            end else begin
                if (pending) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_phase actual=phase required=none");
                        pending = 0;
                    end else if (!ro_a[act]) begin
                        wcnt++;
                        chk("wait_resp", {30'd0, resp_a[act]}, {30'd0, q[0].resp});
                    end else begin
                        e = q.pop_front();
                        chk("resp", {30'd0, resp_a[act]}, {30'd0, e.resp});
                        chk("waits", wcnt, e.waits);
                        if (e.is_rd) chk("rdata", rdata_a[act], e.rdata);
                        pending = 0;
                    end
                end else begin
                    chk("idle_phase", {29'd0, ro_a[act], resp_a[act]}, {29'd0, 1'b1, 2'b00});
                end
                if (htrans[1] && ro_a[act]) begin
                    pending = 1;
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", {31'd0, ro_a[k]}, 32'd1);
            chk("rst_resp", {30'd0, resp_a[k]}, 32'd0);
            chk("rst_rdata", rdata_a[k], 32'd0);
        end
        @(posedge clk);
        #1;

        // P_WAIT=0: back-to-back write/read, read forwarded from the write.
        act = 0;
        wr(32'h010, 3'd2, 32'hDEADBEEF, 2'b00, 0);
        rd(32'h010, 3'd2, 32'hDEADBEEF, 2'b00, 0);
        // Byte and halfword lane merges.
        wr(32'h010, 3'd2, 32'h11223344, 2'b00, 0);
        wr(32'h013, 3'd0, 32'hAB000000, 2'b00, 0);
        rd(32'h010, 3'd2, 32'hAB223344, 2'b00, 0);
        wr(32'h012, 3'd1, 32'hCDEF0000, 2'b00, 0);
        rd(32'h010, 3'd2, 32'hCDEF3344, 2'b00, 0);
        wr(32'h014, 3'd0, 32'h00000099, 2'b00, 0);
        wr(32'h014, 3'd1, 32'h00007766, 2'b00, 0);
        idle();
        rd(32'h011, 3'd0, 32'hCDEF3344, 2'b00, 0);
        rd(32'h014, 3'd0, 32'hxxxx7766, 2'b00, 0);
        idle();
        // Error cases: array untouched, erroring reads return zero.
        wr(32'h004, 3'd2, 32'h55667788, 2'b00, 0);
        wr(32'h006, 3'd2, 32'hFFFFFFFF, 2'b01, 1);
        rd(32'h004, 3'd2, 32'h55667788, 2'b00, 0);
        rd(32'h001, 3'd2, 32'h00000000, 2'b01, 1);
        rd(32'h003, 3'd1, 32'h00000000, 2'b01, 1);
        rd(32'h000, 3'd3, 32'h00000000, 2'b01, 1);
        wr(32'h404, 3'd2, 32'h01020304, 2'b01, 1);
        rd(32'h404, 3'd2, 32'h00000000, 2'b01, 1);
        rd(32'h004, 3'd2, 32'h55667788, 2'b00, 0);
        idle();

        // P_WAIT=2: two wait states, forwarding across waits, reset in S_WAIT.
        act = 1;
        @(posedge clk); #1;
        wr(32'h020, 3'd2, 32'hA5A5A5A5, 2'b00, 2);
        rd(32'h020, 3'd2, 32'hA5A5A5A5, 2'b00, 2);
        wr(32'h030, 3'd2, 32'h0BADF00D, 2'b00, 2);
        idle();
        xfer(2'b10, 32'h030, 3'd2, 1'b1, 32'h12345678, 32'd0, 2'b00, 2, 1'b1);
        htrans = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, ro_a[1]}, 32'd1);
        chk("rst_mid_resp", {30'd0, resp_a[1]}, 32'd0);
        chk("rst_mid_rdata", rdata_a[1], 32'd0);
        @(posedge clk); #1;
        rd(32'h030, 3'd2, 32'h0BADF00D, 2'b00, 2);
        idle();

        // P_WAIT=1: INCR4 with a BUSY cycle in the middle.
        act = 2;
        hburst = 3'b011;
        @(posedge clk); #1;
        xfer(2'b10, 32'h100, 3'd2, 1'b1, 32'hC0DE0100, 32'd0, 2'b00, 1, 1'b0);
        xfer(2'b11, 32'h104, 3'd2, 1'b1, 32'hC0DE0104, 32'd0, 2'b00, 1, 1'b0);
        xfer(2'b01, 32'h108, 3'd2, 1'b1, 32'h00000000, 32'd0, 2'b00, 0, 1'b0);
        xfer(2'b11, 32'h108, 3'd2, 1'b1, 32'hC0DE0108, 32'd0, 2'b00, 1, 1'b0);
        xfer(2'b11, 32'h10C, 3'd2, 1'b1, 32'hC0DE010C, 32'd0, 2'b00, 1, 1'b0);
        idle();
        hburst = 3'b000;
        rd(32'h100, 3'd2, 32'hC0DE0100, 2'b00, 1);
        rd(32'h104, 3'd2, 32'hC0DE0104, 2'b00, 1);
        rd(32'h108, 3'd2, 32'hC0DE0108, 2'b00, 1);
        rd(32'h10C, 3'd2, 32'hC0DE010C, 2'b00, 1);
        idle();

        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbs_mem.md
AHBS_MEM -- requirements
Module: ahbs_mem

Interface
REQ-001 Parameter P_WAIT, default 0, wait states inserted per OKAY data phase, legal range 0-3.
REQ-002 Parameter P_DEPTH, default 256, number of 32-bit words in the memory array (1 KB window).
REQ-003 I_AHBS_HCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 I_AHBS_HRESET  input  1  reset, synchronous and active-high.
REQ-005 I_AHBS_HSEL  input  1  slave select from decoder.
REQ-006 I_AHBS_HADDR  input  32  transfer address.
REQ-007 I_AHBS_HWDATA  input  32  write data, valid in data phase.
REQ-008 I_AHBS_HSIZE  input  3  000 byte, 001 halfword, 010 word.
REQ-009 I_AHBS_HBURST  input  3  burst type; accepted but not used for addressing.
REQ-010 I_AHBS_HTRANS  input  2  00 IDLE, 01 BUSY, 10 NSEQ, 11 SEQ.
REQ-011 I_AHBS_HWRITE  input  1  1 write, 0 read.
REQ-012 I_AHBS_HREADY  input  1  bus-level HREADY; the previous transfer is complete.
REQ-013 O_AHBS_HRDATA  output  32  read data.
REQ-014 O_AHBS_HREADYOUT  output  1  slave ready; low inserts a wait state.
REQ-015 O_AHBS_HRESP  output  2  00 OKAY, 01 ERROR.

Function
REQ-016 Address phase accepted on an edge with HSEL=1, HREADY=1, and HTRANS[1]=1; HADDR, HSIZE, and HWRITE latched; other phases ignored.
REQ-017 IDLE, BUSY, or HSEL=0 with HREADY=1 -> next data phase zero-wait OKAY, no memory access.
REQ-018 Error conditions at acceptance:
- HSIZE>010;
- halfword with HADDR[0]=1;
- word with HADDR[1:0]!=00;
- HADDR[11:10]!=00.
REQ-019 FSM states: S_IDLE, S_WAIT, S_ERR1, S_ERR2; reset to S_IDLE.
REQ-020 S_IDLE transitions on acceptance:
- error -> S_ERR1;
- P_WAIT>0 -> S_WAIT, wait counter loaded with P_WAIT-1;
- otherwise stay in S_IDLE (zero-wait).
REQ-021 S_WAIT: HREADYOUT=0, HRESP=00; counter decrements each cycle; at 0 the next cycle is the completing cycle with HREADYOUT=1; a new acceptance on that completing edge re-enters the decision of REQ-020.
REQ-022 S_ERR1: HREADYOUT=0, HRESP=01, one cycle; S_ERR2: HREADYOUT=1, HRESP=01, one cycle; then S_IDLE; any transfer accepted on the S_ERR2 edge is processed normally.
REQ-023 Write: array updated on the completing edge of the data phase, byte lanes only.
- Byte: lane HADDR[1:0].
- Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
- Word: all four lanes.
- Word index is HADDR[9:2].
REQ-024 Read: HRDATA registered from the word at HADDR[9:2] on the acceptance edge, held through wait states; full 32-bit word returned regardless of HSIZE.
REQ-025 Forwarding: a read accepted on the same edge that completes a write to the same word returns the merged post-write word.
REQ-026 Erroring transfers do not modify the array; HRDATA=0 for an erroring read.
REQ-027 HRDATA holds its last value outside read data phases.
REQ-028 Memory contents are not cleared by reset.

Reset
REQ-029 With HRESET=1 at an edge: state=S_IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, wait counter=0, latched phase cleared.
REQ-030 Reset mid-transfer (S_WAIT or S_ERR1): transfer is abandoned, no array write, REQ-029 values on the next cycle.

Verification
REQ-031 P_WAIT=0: write word 0xDEADBEEF to 0x010, then read 0x010 back-to-back -> read data phase HRDATA=0xDEADBEEF via forwarding, HREADYOUT=1 throughout.
REQ-032 P_WAIT=2: read 0x020 -> HREADYOUT low for exactly 2 cycles, then high with HRDATA valid, HRESP=00.
REQ-033 Byte write 0xAB at 0x013 over word 0x11223344 -> read 0x010 returns 0xAB223344; halfword 0xCDEF at 0x012 -> 0xCDEF3344.
REQ-034 Word write to 0x006 -> HRESP=01 for 2 cycles with HREADYOUT 0 then 1; subsequent read of 0x004 shows unchanged data.
REQ-035 INCR4 burst NSEQ/SEQ/BUSY/SEQ/SEQ at 0x100 with P_WAIT=1 -> BUSY phase zero-wait OKAY, four words written at 0x100-0x10C.
REQ-036 HRESET asserted in S_WAIT of a write to 0x030 -> next cycle HREADYOUT=1, HRESP=00; 0x030 unchanged.
